dly_sel_sequencer: RTL and testbench
====================================

// Module: dly_sel_sequencer
// PURPOSE
//  Command sequencer driving DLY_SEL_DECODER's DLY_LOAD/DLY_ADJ/DLY_INCDEC/DLY_ADDR bus.
//  Accepts one delay request at a time by valid/ready handshake.
//  Converts it into correctly spaced strobes for one of NUM_DLY I_DELAY channels.
//  Keeps a shadow tap count per channel, so SET requests become a train of inc/dec strobes.
// PARAMETERS
//  NUM_DLY   20  number of addressable delay channels; legal addresses are 0..NUM_DLY-1
//  TAP_W     6   shadow tap counter width
//  MAX_TAP   63  highest tap value; shadow saturates here
//  INIT_TAP  0   shadow value after reset and after a LOAD
//  GAP_CYC   2   idle cycles after each strobe, >=1, so ADJ/LOAD edges stay separated
// PORTS
//  CLK         in   1      clock
//  RST         in   1      asynchronous reset, active-high
//  REQ_VALID   in   1      request valid
//  REQ_READY   out  1      request ready; high only in IDLE
//  REQ_OP      in   2      00 LOAD, 01 INC, 10 DEC, 11 SET
//  REQ_ADDR    in   5      target channel
//  REQ_TAP     in   TAP_W  SET target; values >MAX_TAP are clamped to MAX_TAP
//  DLY_LOAD    out  1      load strobe to decoder
//  DLY_ADJ     out  1      adjust strobe to decoder
//  DLY_INCDEC  out  1      1=increment, 0=decrement
//  DLY_ADDR    out  5      channel select to decoder
//  DONE        out  1      1-cycle pulse: request completed
//  ERR         out  1      1-cycle pulse: request rejected (REQ_ADDR>=NUM_DLY)
//  CUR_TAP     out  TAP_W  shadow tap of last request's channel; valid when DONE=1
// BEHAVIOUR
//  - Every output is registered.
//  - Reset values: all outputs 0 except REQ_READY=1; CUR_TAP=INIT_TAP; all shadows=INIT_TAP; state IDLE.
//  - Accept: on an edge with REQ_VALID & REQ_READY, latch op/addr/tap.
//    - REQ_READY drops in the cycle after the accept edge (cycle 1).
//  - States: IDLE -> SETUP -> PULSE -> GAP -> (PULSE | DONE) -> IDLE; IDLE -> FIN -> IDLE.
//  - FIN (no strobe, cycle 1) is taken in these cases:
//    - bad address: ERR=1;
//    - INC with shadow=MAX_TAP, DEC with shadow=0, or SET with shadow=target: DONE=1, shadow unchanged.
//  - SETUP (cycle 1):
//    - DLY_ADDR <= addr; DLY_INCDEC <= direction (INC, or SET with target>shadow);
//    - LOAD/ADJ stay 0. DLY_ADDR and DLY_INCDEC only change while LOAD=ADJ=0.
//  - PULSE (1 cycle):
//    - LOAD op: DLY_LOAD=1 and shadow<=INIT_TAP;
//    - otherwise DLY_ADJ=1 and shadow +/-1.
//  - GAP (GAP_CYC cycles): strobes 0; ADDR and INCDEC held.
//    - Exit to PULSE if SET and shadow!=target, else to DONE.
//  - DONE (1 cycle): DONE=1, CUR_TAP=shadow[addr]. REQ_READY=1 in the next cycle.
//  - Single strobe timing: strobe in cycle 2, DONE in cycle 3+GAP_CYC.
//  - SET with k steps: strobes in cycles 2+i*(1+GAP_CYC), i=0..k-1; DONE in cycle 2+k*(1+GAP_CYC).
//  - Idle outputs: DLY_LOAD=DLY_ADJ=DLY_INCDEC=0; DLY_ADDR holds its last value.
//  - Shadow saturates at 0 and MAX_TAP; it never wraps.
//  - REQ_VALID while busy is ignored. The requester must hold its request until REQ_READY.
//  - RST mid-operation: outputs go to reset values immediately (asynchronous), no DONE is issued,
//    shadows return to INIT_TAP.
// TESTING
//  T1 reset: assert RST mid-run -> same cycle DLY_*=0, DONE=ERR=0, REQ_READY=1;
//     then INC addr 0 -> CUR_TAP=1.
//  T2 INC addr 7 from reset (GAP_CYC=2) -> ADDR=7/INCDEC=1 cycle 1, ADJ=1 only cycle 2,
//     DONE cycle 5, CUR_TAP=1.
//  T3 SET addr 19 tap 4, then SET tap 1 -> 4 ADJ pulses INCDEC=1 cycles 2,5,8,11 (DONE 14, CUR_TAP=4);
//     then 3 pulses INCDEC=0, CUR_TAP=1.
//  T4 DEC addr 2 at tap 0; SET addr 5 tap 63 then INC -> DEC gives DONE cycle 1 with no strobe;
//     SET ends with CUR_TAP=63; INC gives no strobe and CUR_TAP=63.
//  T5 REQ_ADDR=20 and 31 -> ERR cycle 1, no strobe, no DONE, REQ_READY=1 cycle 2;
//     also SET tap>MAX_TAP is clamped.
//  T6 closed loop through DLY_SEL_DECODER, random 200 ops (LOAD/INC/DEC/SET) ->
//     only DLYn_CNTRL with n=addr ever nonzero; count per-channel ADJ edges and compare to shadow model.

Source files
------------

// File: rtl/dly_sel_sequencer.sv
// dly_sel_sequencer
//   Turns one delay request at a time (valid/ready) into spaced LOAD/ADJ
//   strobes on the DLY_SEL_DECODER bus. It keeps a shadow tap count per
//   channel, so a SET request becomes a train of single inc/dec strobes.
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   REQ_VALID/REQ_READY      request handshake (READY high only while idle)
//   REQ_OP                   00 LOAD, 01 INC, 10 DEC, 11 SET
//   REQ_ADDR, REQ_TAP        target channel, SET target tap
//   DLY_LOAD/ADJ/INCDEC/ADDR decoder command bus
//   DONE, ERR                1-cycle completion / reject pulses
//   CUR_TAP                  shadow tap of the last channel, valid with DONE
module dly_sel_sequencer #(
  parameter int unsigned NUM_DLY  = 20,
  parameter int unsigned TAP_W    = 6,
  parameter int unsigned MAX_TAP  = 63,
  parameter int unsigned INIT_TAP = 0,
  parameter int unsigned GAP_CYC  = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [1:0]       REQ_OP,
  input  logic [4:0]       REQ_ADDR,
  input  logic [TAP_W-1:0] REQ_TAP,
  output logic             DLY_LOAD,
  output logic             DLY_ADJ,
  output logic             DLY_INCDEC,
  output logic [4:0]       DLY_ADDR,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_TAP
);

  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [TAP_W-1:0] C_MAX  = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] C_INIT = TAP_W'(INIT_TAP);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_DONE, S_FIN
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_SET = 2'b11
  } op_t;

  state_t           r_state, w_state_nxt;
  op_t              r_op, w_req_op;
  logic [4:0]       r_addr;
  logic [TAP_W-1:0] r_tgt;
  logic [GW-1:0]    r_gap, w_gap_nxt;
  logic [TAP_W-1:0] r_shadow [NUM_DLY];

  logic             w_ready_nxt, w_load_nxt, w_adj_nxt, w_incdec_nxt;
  logic             w_done_nxt, w_err_nxt;
  logic [4:0]       w_addr_nxt;
  logic [TAP_W-1:0] w_cur_nxt;
  logic             w_accept, w_shadow_we;
  logic [TAP_W-1:0] w_req_shadow, w_cur_shadow, w_shadow_nxt, w_req_tgt;
  logic [31:0]      w_req_tap32;
  logic             w_req_ok, w_req_noop, w_req_dir;

  assign w_req_op    = op_t'(REQ_OP);
  assign w_req_tap32 = {{(32-TAP_W){1'b0}}, REQ_TAP};
  assign w_req_tgt   = (w_req_tap32 > MAX_TAP) ? C_MAX : REQ_TAP;
  assign w_req_ok    = ({27'd0, REQ_ADDR} < NUM_DLY);

  // Shadow read ports: one for the incoming request, one for the latched channel
  always_comb begin
    w_req_shadow = '0;
    w_cur_shadow = '0;
    for (int unsigned i = 0; i < NUM_DLY; i++) begin
      if (REQ_ADDR == 5'(i)) w_req_shadow = r_shadow[i];
      if (r_addr == 5'(i))   w_cur_shadow = r_shadow[i];
    end
  end

  // Requests that would not move the shadow finish without a strobe
  always_comb begin
    w_req_noop = 1'b0;
    w_req_dir  = 1'b0;
    case (w_req_op)
      OP_INC: begin
        w_req_noop = (w_req_shadow == C_MAX);
        w_req_dir  = 1'b1;
      end
      OP_DEC: w_req_noop = (w_req_shadow == '0);
      OP_SET: begin
        w_req_noop = (w_req_shadow == w_req_tgt);
        w_req_dir  = (w_req_tgt > w_req_shadow);
      end
      default: begin
        w_req_noop = 1'b0;
        w_req_dir  = 1'b0;
      end
    endcase
  end

  // DLY_INCDEC already holds the direction of the running request
  always_comb begin
    if (r_op == OP_LOAD)
      w_shadow_nxt = C_INIT;
    else if (DLY_INCDEC)
      w_shadow_nxt = (w_cur_shadow == C_MAX) ? w_cur_shadow : w_cur_shadow + 1'b1;
    else
      w_shadow_nxt = (w_cur_shadow == '0) ? w_cur_shadow : w_cur_shadow - 1'b1;
  end

  // Outputs are registered, so each branch prepares what the next state shows
  always_comb begin
    w_state_nxt  = r_state;
    w_gap_nxt    = r_gap;
    w_ready_nxt  = 1'b0;
    w_load_nxt   = 1'b0;
    w_adj_nxt    = 1'b0;
    w_incdec_nxt = DLY_INCDEC;
    w_addr_nxt   = DLY_ADDR;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_cur_nxt    = CUR_TAP;
    w_accept     = 1'b0;
    w_shadow_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        if (REQ_VALID && REQ_READY) begin
          w_accept    = 1'b1;
          w_ready_nxt = 1'b0;
          if (!w_req_ok) begin
            w_state_nxt = S_FIN;
            w_err_nxt   = 1'b1;
          end else if (w_req_noop) begin
            w_state_nxt = S_FIN;
            w_done_nxt  = 1'b1;
            w_cur_nxt   = w_req_shadow;
          end else begin
            w_state_nxt  = S_SETUP;
            w_addr_nxt   = REQ_ADDR;
            w_incdec_nxt = w_req_dir;
          end
        end
      end
      S_SETUP: begin
        w_state_nxt = S_PULSE;
        w_shadow_we = 1'b1;
        if (r_op == OP_LOAD) w_load_nxt = 1'b1;
        else                 w_adj_nxt  = 1'b1;
      end
      S_PULSE: begin
        w_state_nxt = S_GAP;
        w_gap_nxt   = '0;
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYC - 1)) begin
          if (r_op == OP_SET && w_cur_shadow != r_tgt) begin
            w_state_nxt = S_PULSE;
            w_adj_nxt   = 1'b1;
            w_shadow_we = 1'b1;
          end else begin
            w_state_nxt  = S_DONE;
            w_done_nxt   = 1'b1;
            w_cur_nxt    = w_cur_shadow;
            w_incdec_nxt = 1'b0;
          end
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_op       <= OP_LOAD;
      r_addr     <= '0;
      r_tgt      <= '0;
      r_gap      <= '0;
      REQ_READY  <= 1'b1;
      DLY_LOAD   <= 1'b0;
      DLY_ADJ    <= 1'b0;
      DLY_INCDEC <= 1'b0;
      DLY_ADDR   <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      CUR_TAP    <= C_INIT;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      REQ_READY  <= w_ready_nxt;
      DLY_LOAD   <= w_load_nxt;
      DLY_ADJ    <= w_adj_nxt;
      DLY_INCDEC <= w_incdec_nxt;
      DLY_ADDR   <= w_addr_nxt;
      DONE       <= w_done_nxt;
      ERR        <= w_err_nxt;
      CUR_TAP    <= w_cur_nxt;
      if (w_accept) begin
        r_op   <= w_req_op;
        r_addr <= REQ_ADDR;
        r_tgt  <= w_req_tgt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NUM_DLY; i++) r_shadow[i] <= C_INIT;
    end else begin
      for (int unsigned i = 0; i < NUM_DLY; i++)
        if (w_shadow_we && r_addr == 5'(i)) r_shadow[i] <= w_shadow_nxt;
    end
  end

endmodule

// File: tb/tb_dly_sel_sequencer.sv
module tb_dly_sel_sequencer;

  localparam int NUM  = 20;
  localparam int MAXT = 63;
  localparam int INIT = 0;
  localparam int G    = 2;
  localparam int BUDGET = 300;

  logic       CLK = 1'b0;
  logic       RST;
  logic       REQ_VALID;
  logic       REQ_READY;
  logic [1:0] REQ_OP;
  logic [4:0] REQ_ADDR;
  logic [5:0] REQ_TAP;
  logic       DLY_LOAD, DLY_ADJ, DLY_INCDEC;
  logic [4:0] DLY_ADDR;
  logic       DONE, ERR;
  logic [5:0] CUR_TAP;

  int n_cmp  = 0;
  int n_fail = 0;
  int sh     [NUM];
  int adjnet [NUM];

  dly_sel_sequencer #(
    .NUM_DLY (NUM),
    .TAP_W   (6),
    .MAX_TAP (MAXT),
    .INIT_TAP(INIT),
    .GAP_CYC (G)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_TAP   (REQ_TAP),
    .DLY_LOAD  (DLY_LOAD),
    .DLY_ADJ   (DLY_ADJ),
    .DLY_INCDEC(DLY_INCDEC),
    .DLY_ADDR  (DLY_ADDR),
    .DONE      (DONE),
    .ERR       (ERR),
    .CUR_TAP   (CUR_TAP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      sh[i]     = INIT;
      adjnet[i] = 0;
    end
  endtask

  // Called at a sample point (#1 after a rising edge)
  task automatic wait_ready();
    int n = 0;
    while (REQ_READY !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ready_wait", {31'd0, REQ_READY}, 1);
  endtask

  task automatic do_req(input int op, input int addr, input int tap, input bit noise);
    int k, dir, tgt, exp_cur, exp_done, exp_err;
    int nstr, obs_done, obs_err;
    logic [4:0] prev_addr;
    logic       prev_incdec;
    bit seen_end;

    // Reference model: what the request should do, in plain arithmetic
    k = 0; dir = 0; exp_cur = 0; exp_done = -1; exp_err = -1;
    tgt = (tap > MAXT) ? MAXT : tap;
    if (addr >= NUM) begin
      exp_err = 1;
    end else begin
      case (op)
        0: begin k = 1; exp_cur = INIT; end
        1: begin k = (sh[addr] < MAXT) ? 1 : 0; dir = 1; exp_cur = sh[addr] + k; end
        2: begin k = (sh[addr] > 0) ? 1 : 0; exp_cur = sh[addr] - k; end
        default: begin
          k = (tgt > sh[addr]) ? tgt - sh[addr] : sh[addr] - tgt;
          dir = (tgt > sh[addr]) ? 1 : 0;
          exp_cur = tgt;
        end
      endcase
      exp_done = (k == 0) ? 1 : 2 + k * (1 + G);
      sh[addr] = exp_cur;
    end

    wait_ready();
    REQ_VALID = 1'b1;
    REQ_OP    = 2'(op);
    REQ_ADDR  = 5'(addr);
    REQ_TAP   = 6'(tap);
    prev_addr   = DLY_ADDR;
    prev_incdec = DLY_INCDEC;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;

    nstr = 0; obs_done = -1; obs_err = -1; seen_end = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !seen_end; cyc++) begin
      if (cyc > 1) begin @(posedge CLK); #1; end
      if (cyc == 1) chk("ready_low", {31'd0, REQ_READY}, 0);
      if (DLY_LOAD || DLY_ADJ) begin
        if (nstr < k) begin
          chk("strobe_cyc", cyc, 2 + nstr * (1 + G));
          chk("strobe_kind", {30'd0, DLY_LOAD, DLY_ADJ}, (op == 0) ? 2 : 1);
          chk("strobe_dir", {31'd0, DLY_INCDEC}, dir);
          chk("strobe_addr", {27'd0, DLY_ADDR}, addr);
          chk("strobe_hold", {26'd0, DLY_ADDR, DLY_INCDEC}, {26'd0, prev_addr, prev_incdec});
        end else begin
          chk("extra_strobe", nstr + 1, k);
        end
        if (DLY_ADDR < NUM) begin
          if (DLY_LOAD) adjnet[DLY_ADDR] = 0;
          else adjnet[DLY_ADDR] += DLY_INCDEC ? 1 : -1;
        end
        nstr++;
      end
      if (DONE === 1'b1) begin
        obs_done = cyc;
        chk("cur_tap", {26'd0, CUR_TAP}, exp_cur);
      end
      if (ERR === 1'b1) obs_err = cyc;
      if (DONE === 1'b1 || ERR === 1'b1) seen_end = 1'b1;
      prev_addr   = DLY_ADDR;
      prev_incdec = DLY_INCDEC;
      if (noise && !seen_end) begin
        REQ_VALID = 1'b1;
        REQ_OP    = 2'($urandom_range(0, 3));
        REQ_ADDR  = 5'($urandom_range(0, 31));
        REQ_TAP   = 6'($urandom_range(0, 63));
      end else begin
        REQ_VALID = 1'b0;
      end
    end
    REQ_VALID = 1'b0;
    chk("n_strobes", nstr, k);
    chk("done_cyc", obs_done, exp_done);
    chk("err_cyc", obs_err, exp_err);
    if (seen_end) begin
      @(posedge CLK); #1;
      chk("ready_back", {31'd0, REQ_READY}, 1);
      chk("idle_outs", {27'd0, DLY_LOAD, DLY_ADJ, DLY_INCDEC, DONE, ERR}, 0);
      chk("idle_addr", {27'd0, DLY_ADDR}, {27'd0, prev_addr});
    end
  endtask

  initial begin
    RST = 1'b1; REQ_VALID = 1'b0; REQ_OP = '0; REQ_ADDR = '0; REQ_TAP = '0;
    model_reset();
    #12;
    chk("rst_ready", {31'd0, REQ_READY}, 1);
    chk("rst_outs", {27'd0, DLY_LOAD, DLY_ADJ, DLY_INCDEC, DONE, ERR}, 0);
    chk("rst_addr", {27'd0, DLY_ADDR}, 0);
    chk("rst_cur", {26'd0, CUR_TAP}, INIT);
    #10 RST = 1'b0;
    @(posedge CLK); #1;

    // Reset in the middle of a SET train
    wait_ready();
    REQ_VALID = 1'b1; REQ_OP = 2'b11; REQ_ADDR = 5'd3; REQ_TAP = 6'd10;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, REQ_READY}, 1);
    chk("midrst_outs", {27'd0, DLY_LOAD, DLY_ADJ, DLY_INCDEC, DONE, ERR}, 0);
    chk("midrst_addr", {27'd0, DLY_ADDR}, 0);
    model_reset();
    @(posedge CLK); #3 RST = 1'b0;
    @(posedge CLK); #1;
    do_req(1, 0, 0, 0);

    // Single INC, SET up/down, saturation and no-op cases
    do_req(1, 7, 0, 0);
    do_req(3, 19, 4, 0);
    do_req(3, 19, 1, 0);
    do_req(2, 2, 0, 0);
    do_req(3, 5, 63, 0);
    do_req(1, 5, 0, 0);
    do_req(3, 5, 63, 0);
    do_req(2, 5, 0, 0);
    // Rejected addresses
    do_req(1, 20, 0, 0);
    do_req(3, 31, 63, 0);
    // LOAD and busy-time request noise
    do_req(0, 19, 0, 0);
    do_req(0, 4, 0, 0);
    do_req(3, 11, 9, 1);
    do_req(2, 11, 0, 1);

    for (int n = 0; n < 200; n++) begin
      int op, addr, tap;
      op   = $urandom_range(0, 3);
      addr = ($urandom_range(0, 15) == 0) ? $urandom_range(20, 31) : $urandom_range(0, 19);
      tap  = $urandom_range(0, 63);
      do_req(op, addr, tap, $urandom_range(0, 3) == 0);
    end

    // Net observed strobes per channel must reproduce the shadow model
    for (int i = 0; i < NUM; i++) chk("adj_net", adjnet[i] + INIT, sh[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
